// File: rtl/alarm_ringer_pkg.sv
// Shared definitions for the alarm ringer: FSM state encodings, the 1 Hz tick
// width and helpers that size the second and snooze counters.
package alarm_ringer_pkg;

    // FSM state encodings, kept as plain constants so legacy code can match them.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RING   = 2'd1;
    localparam state_t ST_SNOOZE = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // Width of the 1 Hz tick strobe coming from the clock chain.
    localparam int TICK_W = 1;

    // Bits needed for a seconds counter that must reach max(a, b) - 1.
    function automatic int sec_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Bits needed to hold a count from 0 to max_cnt inclusive.
    function automatic int cnt_width(input int max_cnt);
        return (max_cnt > 0) ? $clog2(max_cnt + 1) : 1;
    endfunction

endpackage

// File: rtl/alarm_ringer_if.sv
// Alarm ringer signal bundle: comparator/keys/tick in, buzzer and status out.
// master = upstream logic driving the inputs, slave = the ringer itself.
import alarm_ringer_pkg::*;

interface alarm_ringer_if #(
    parameter int SNOOZE_MAX = 3
);
    localparam int CNT_W = cnt_width(SNOOZE_MAX);

    logic              alarm_match;
    logic              alarm_enable;
    logic [TICK_W-1:0] sec_tick;
    logic              stop_key;
    logic              snooze_key;
    logic              buzz;
    logic              ringing;
    logic              snoozing;
    logic [CNT_W-1:0]  snooze_cnt;

    modport master (
        output alarm_match, alarm_enable, sec_tick, stop_key, snooze_key,
        input  buzz, ringing, snoozing, snooze_cnt
    );

    modport slave (
        input  alarm_match, alarm_enable, sec_tick, stop_key, snooze_key,
        output buzz, ringing, snoozing, snooze_cnt
    );

endinterface

// File: rtl/alarm_ringer_beep.sv
// beep_pattern_gen: square-wave cadence for the buzzer, BEEP_HALF clk cycles on
// then BEEP_HALF off. buzz_phase is the phase the generator will hold after the
// coming edge, so the parent can register buzz in the same cycle as its state.
module beep_pattern_gen #(
    parameter int BEEP_HALF = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,      // entering RING this cycle: restart in the high phase
    input  logic run,        // staying in RING this cycle: advance the cadence
    output logic buzz_phase
);

    localparam int BW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEEP_HALF - 1);

    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic          phase_q, phase_d;

    // Next cadence position: restart on entry, advance while ringing, idle low otherwise.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        beep_cnt_d = beep_cnt_q;
        phase_d    = phase_q;
        if (start) begin
            beep_cnt_d = '0;
            phase_d    = 1'b1;
        end else if (run) begin
            if (beep_cnt_q == LAST) begin
                beep_cnt_d = '0;
                phase_d    = ~phase_q;
            end else begin
                beep_cnt_d = beep_cnt_q + 1'b1;
            end
        end else begin
            beep_cnt_d = '0;
            phase_d    = 1'b0;
        end
    end

    assign buzz_phase = phase_d;

    // Cadence registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            beep_cnt_q <= beep_cnt_d;
            phase_q    <= phase_d;
        end
    end

endmodule

// File: rtl/alarm_ringer.sv
// alarm_ringer: turns the alarm comparator's level match into an intermittent
// buzz that ends on stop key or timeout, with optional snooze.
// Optional feature: define ALARM_RINGER_SNOOZE_EN to build the SNOOZE state,
// the snooze counter and snooze_key handling; otherwise snooze_key is ignored
// and snoozing/snooze_cnt read 0.
module alarm_ringer
    import alarm_ringer_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int SNOOZE_MAX = 3,
    parameter int BEEP_HALF  = 8
) (
    input  logic         clk,
    input  logic         rst,
    alarm_ringer_if.slave bus
);

    localparam int SEC_W = sec_width(RING_SEC, SNOOZE_SEC);
    localparam int CNT_W = cnt_width(SNOOZE_MAX);

    localparam logic [SEC_W-1:0] RING_LAST = SEC_W'(RING_SEC - 1);

    state_t           state_q, state_d;
    logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
    logic             match_prev_q, match_prev_d;
    logic             ringing_q, ringing_d;
    logic             buzz_q, buzz_d;
    logic             rise;
    logic             beep_start, beep_run, buzz_phase;

`ifdef ALARM_RINGER_SNOOZE_EN
    localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);
    localparam logic [CNT_W-1:0] SNZ_LIMIT   = CNT_W'(SNOOZE_MAX);

    logic [CNT_W-1:0] snooze_cnt_q, snooze_cnt_d;
    logic             snoozing_q, snoozing_d;
`endif

    // Previous-cycle copy of alarm_match; a fresh match is a 0->1 step.
    assign match_prev_d = bus.alarm_match;
    assign rise         = bus.alarm_match & ~match_prev_q;

    // Next-state logic. Priority: disable > stop > snooze > second tick,
    // so a key arriving with a tick consumes that tick.
    always_comb begin
        state_d   = state_q;
        sec_cnt_d = sec_cnt_q;
`ifdef ALARM_RINGER_SNOOZE_EN
        snooze_cnt_d = snooze_cnt_q;
`endif
        if (!bus.alarm_enable) begin
            state_d   = ST_IDLE;
            sec_cnt_d = '0;
`ifdef ALARM_RINGER_SNOOZE_EN
            snooze_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d   = ST_RING;
                        sec_cnt_d = '0;
`ifdef ALARM_RINGER_SNOOZE_EN
                        snooze_cnt_d = '0;
`endif
                    end
                end

                ST_RING: begin
                    if (bus.stop_key) begin
                        state_d = ST_DONE;
`ifdef ALARM_RINGER_SNOOZE_EN
                    end else if (bus.snooze_key) begin
                        // Snoozes beyond the allowance end the alarm outright.
                        if (snooze_cnt_q < SNZ_LIMIT) begin
                            state_d      = ST_SNOOZE;
                            snooze_cnt_d = snooze_cnt_q + 1'b1;
                            sec_cnt_d    = '0;
                        end else begin
                            state_d = ST_DONE;
                        end
`endif
                    end else if (bus.sec_tick != '0) begin
                        if (sec_cnt_q == RING_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            sec_cnt_d = sec_cnt_q + 1'b1;
                        end
                    end
                end

`ifdef ALARM_RINGER_SNOOZE_EN
                ST_SNOOZE: begin
                    // Re-ring is purely time based; alarm_match is not consulted.
                    if (bus.stop_key) begin
                        state_d = ST_DONE;
                    end else if (bus.sec_tick != '0) begin
                        if (sec_cnt_q == SNOOZE_LAST) begin
                            state_d   = ST_RING;
                            sec_cnt_d = '0;
                        end else begin
                            sec_cnt_d = sec_cnt_q + 1'b1;
                        end
                    end
                end
`endif

                ST_DONE: begin
                    // Hold off until the matching minute has passed.
                    if (!bus.alarm_match) begin
                        state_d = ST_IDLE;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Beep cadence restarts on every entry to RING and advances while it stays.
    assign beep_start = (state_d == ST_RING) && (state_q != ST_RING);
    assign beep_run   = (state_d == ST_RING) && (state_q == ST_RING);

    beep_pattern_gen #(
        .BEEP_HALF (BEEP_HALF)
    ) u_beep (
        .clk        (clk),
        .rst        (rst),
        .start      (beep_start),
        .run        (beep_run),
        .buzz_phase (buzz_phase)
    );

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        ringing_d = (state_d == ST_RING);
        buzz_d    = (state_d == ST_RING) && buzz_phase;
`ifdef ALARM_RINGER_SNOOZE_EN
        snoozing_d = (state_d == ST_SNOOZE);
`endif
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: match_prev resets high so a match already present at reset
            // release is not seen as a rising edge.
            state_q      <= ST_IDLE;
            sec_cnt_q    <= '0;
            match_prev_q <= 1'b1;
            ringing_q    <= 1'b0;
            buzz_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            match_prev_q <= match_prev_d;
            ringing_q    <= ringing_d;
            buzz_q       <= buzz_d;
        end
    end

`ifdef ALARM_RINGER_SNOOZE_EN
    // Snooze bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snooze_cnt_q <= '0;
            snoozing_q   <= 1'b0;
        end else begin
            snooze_cnt_q <= snooze_cnt_d;
            snoozing_q   <= snoozing_d;
        end
    end

    assign bus.snoozing   = snoozing_q;
    assign bus.snooze_cnt = snooze_cnt_q;
`else
    assign bus.snoozing   = 1'b0;
    assign bus.snooze_cnt = CNT_W'(0);
`endif

    assign bus.ringing = ringing_q;
    assign bus.buzz    = buzz_q;

endmodule
